// File: rtl/serial_frame_tx.sv
// Framing serializer: preamble, SFD, payload, CRC-8, one bit per clk108 cycle, MSB first.
// Latency: first preamble bit on tx_bit the cycle after the first byte handshake.
// Backpressure: 1-deep holding reg; s_tready low while it is full, during the gap, and in reset.
//
// Ports:
//   clk108, aresetn             bit clock, synchronous active-low reset
//   s_tdata/s_tvalid/s_tready   payload byte stream; s_tlast marks the final byte of a frame
//   tx_bit                      registered serial bit to the ODDR D inputs
//   tx_active                   high while tx_bit carries preamble/SFD/payload/CRC bits
//   frame_done                  1-cycle pulse in the first idle cycle after the CRC byte
//   tx_underrun                 1-cycle pulse when no payload byte is ready at a byte boundary
module serial_frame_tx #(
    parameter logic [7:0]  PREAMBLE_BYTE = 8'hAA,
    parameter int unsigned PREAMBLE_LEN  = 2,
    parameter logic [7:0]  SFD_BYTE      = 8'hD5,
    parameter int unsigned IFG_BITS      = 16,
    parameter logic        IDLE_BIT      = 1'b0
) (
    input  logic       clk108,
    input  logic       aresetn,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    input  logic       s_tlast,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       frame_done,
    output logic       tx_underrun
);

    localparam int PCW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam int GCW = (IFG_BITS > 2) ? $clog2(IFG_BITS - 1) : 1;
    // The IDLE cycle that accepts the next frame's first byte is itself an idle
    // bit-time, so GAP lasts IFG_BITS-1 cycles and the line sees exactly IFG_BITS
    // idle bits between back-to-back frames.
    localparam int GAP_LAST = (IFG_BITS > 1) ? int'(IFG_BITS) - 2 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_PAY,
        ST_CRC,
        ST_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [GCW-1:0] gcnt_q, gcnt_d;
    logic [7:0]     sh_q, sh_d;
    logic [7:0]     crc_q, crc_d;
    logic [7:0]     hold_dat_q, hold_dat_d;
    logic           hold_last_q, hold_last_d;
    logic           hold_valid_q, hold_valid_d;
    logic           cur_last_q, cur_last_d;
    logic           tx_bit_q, tx_bit_d;
    logic           tx_active_q, tx_active_d;
    logic           frame_done_q, frame_done_d;
    logic           tx_underrun_q, tx_underrun_d;
    logic           rdy_en_q, rdy_en_d;

    logic           hs;
    logic           byte_end;
    logic           load;
    logic [7:0]     nxt_byte;
    logic [7:0]     pay_byte;
    logic           pay_last;
    logic           pay_avail;

    // CRC-8, poly 0x07, init 0, MSB first, folded over one whole byte.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // rdy_en_q keeps s_tready low during reset and for the release edge itself.
    assign s_tready = rdy_en_q &
                      ((state_q == ST_IDLE) ||
                       ((state_q == ST_PAY) && !hold_valid_q && !cur_last_q));
    assign hs       = s_tvalid & s_tready;
    assign byte_end = (bcnt_q == 3'd7);

    // A byte handshaken on the boundary edge itself counts as present.
    assign pay_avail = hold_valid_q | hs;
    assign pay_byte  = hold_valid_q ? hold_dat_q  : s_tdata;
    assign pay_last  = hold_valid_q ? hold_last_q : s_tlast;

    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        pcnt_d        = pcnt_q;
        gcnt_d        = gcnt_q;
        sh_d          = sh_q;
        crc_d         = crc_q;
        hold_dat_d    = hold_dat_q;
        hold_last_d   = hold_last_q;
        hold_valid_d  = hold_valid_q;
        cur_last_d    = cur_last_q;
        tx_bit_d      = tx_bit_q;
        tx_active_d   = tx_active_q;
        frame_done_d  = 1'b0;
        tx_underrun_d = 1'b0;
        rdy_en_d      = 1'b1;
        load          = 1'b0;
        nxt_byte      = 8'h00;

        case (state_q)
            ST_IDLE: begin
                tx_bit_d    = IDLE_BIT;
                tx_active_d = 1'b0;
                if (hs) begin
                    hold_dat_d   = s_tdata;
                    hold_last_d  = s_tlast;
                    hold_valid_d = 1'b1;
                    cur_last_d   = 1'b0;
                    crc_d        = 8'h00;
                    pcnt_d       = '0;
                    bcnt_d       = 3'd0;
                    tx_active_d  = 1'b1;
                    state_d      = ST_PRE;
                    load         = 1'b1;
                    nxt_byte     = PREAMBLE_BYTE;
                end
            end

            ST_PRE, ST_SFD, ST_PAY, ST_CRC: begin
                if (state_q == ST_PAY && hs) begin
                    hold_dat_d   = s_tdata;
                    hold_last_d  = s_tlast;
                    hold_valid_d = 1'b1;
                end
                if (!byte_end) begin
                    bcnt_d   = bcnt_q + 3'd1;
                    sh_d     = {sh_q[6:0], 1'b0};
                    tx_bit_d = sh_q[6];
                end else begin
                    bcnt_d = 3'd0;
                    case (state_q)
                        ST_PRE: begin
                            load = 1'b1;
                            if (pcnt_q == PCW'(PREAMBLE_LEN - 1)) begin
                                state_d  = ST_SFD;
                                nxt_byte = SFD_BYTE;
                            end else begin
                                pcnt_d   = pcnt_q + PCW'(1);
                                nxt_byte = PREAMBLE_BYTE;
                            end
                        end
                        ST_SFD: begin
                            // Holding reg is always full here: the frame opened with it.
                            state_d      = ST_PAY;
                            load         = 1'b1;
                            nxt_byte     = hold_dat_q;
                            cur_last_d   = hold_last_q;
                            hold_valid_d = 1'b0;
                            crc_d        = crc8_byte(crc_q, hold_dat_q);
                        end
                        ST_PAY: begin
                            load = 1'b1;
                            if (cur_last_q) begin
                                state_d  = ST_CRC;
                                nxt_byte = crc_q;
                            end else if (pay_avail) begin
                                nxt_byte     = pay_byte;
                                cur_last_d   = pay_last;
                                hold_valid_d = 1'b0;
                                crc_d        = crc8_byte(crc_q, pay_byte);
                            end else begin
                                // Starved mid-frame: close it with an inverted CRC so
                                // the receiver discards the truncated frame.
                                tx_underrun_d = 1'b1;
                                state_d       = ST_CRC;
                                nxt_byte      = ~crc_q;
                            end
                        end
                        default: begin
                            frame_done_d = 1'b1;
                            tx_active_d  = 1'b0;
                            tx_bit_d     = IDLE_BIT;
                            cur_last_d   = 1'b0;
                            gcnt_d       = '0;
                            state_d      = (IFG_BITS > 1) ? ST_GAP : ST_IDLE;
                        end
                    endcase
                end
            end

            ST_GAP: begin
                tx_bit_d    = IDLE_BIT;
                tx_active_d = 1'b0;
                if (gcnt_q == GCW'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GCW'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                tx_bit_d    = IDLE_BIT;
                tx_active_d = 1'b0;
            end
        endcase

        if (load) begin
            sh_d     = nxt_byte;
            tx_bit_d = nxt_byte[7];
        end
    end

    always_ff @(posedge clk108) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            bcnt_q        <= 3'd0;
            pcnt_q        <= '0;
            gcnt_q        <= '0;
            sh_q          <= 8'h00;
            crc_q         <= 8'h00;
            hold_dat_q    <= 8'h00;
            hold_last_q   <= 1'b0;
            hold_valid_q  <= 1'b0;
            cur_last_q    <= 1'b0;
            tx_bit_q      <= IDLE_BIT;
            tx_active_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            rdy_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            pcnt_q        <= pcnt_d;
            gcnt_q        <= gcnt_d;
            sh_q          <= sh_d;
            crc_q         <= crc_d;
            hold_dat_q    <= hold_dat_d;
            hold_last_q   <= hold_last_d;
            hold_valid_q  <= hold_valid_d;
            cur_last_q    <= cur_last_d;
            tx_bit_q      <= tx_bit_d;
            tx_active_q   <= tx_active_d;
            frame_done_q  <= frame_done_d;
            tx_underrun_q <= tx_underrun_d;
            rdy_en_q      <= rdy_en_d;
        end
    end

    assign tx_bit      = tx_bit_q;
    assign tx_active   = tx_active_q;
    assign frame_done  = frame_done_q;
    assign tx_underrun = tx_underrun_q;

endmodule
